// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler input-side blocks.
package scaler_pkg;

  localparam int DEF_INPUT_RES_WIDTH = 11;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } res_state_t;

endpackage

// File: rtl/scaler_sync_edge.sv
// Sync edge detector: flags the cycle a sync is sampled at its active level
// when the previous-cycle sample was not active.
module scaler_sync_edge #(
  parameter bit SYNC_POL = 1'b1
) (
  input  logic clka,
  input  logic rst,
  input  logic sync_lvl,
  output logic act_edge
);

  logic act;
  logic act_q;

  assign act = (sync_lvl == SYNC_POL);

  always_ff @(posedge clka or posedge rst) begin
    if (rst) act_q <= 1'b0;
    else     act_q <= act;
  end

  assign act_edge = act & ~act_q;

endmodule

// File: rtl/scaler_res_detect.sv
// Input resolution detector: measures active pixels/line and lines/frame and
// publishes a full-frame window once STABLE_FRAMES identical valid frames arrive.
//
// state   | meaning
// SEARCH  | waiting for the first vsync edge; partial frame discarded
// MEASURE | counting consecutive identical valid frames
// LOCKED  | published resolution valid, watching for changes
module scaler_res_detect
  import scaler_pkg::*;
#(
  parameter int INPUT_RES_WIDTH = DEF_INPUT_RES_WIDTH,
  parameter int STABLE_FRAMES   = 2,
  parameter bit SYNC_POL        = 1'b1
) (
  input  logic                       clka,
  input  logic                       rst,
  input  logic                       iHsyn,
  input  logic                       iVsyn,
  input  logic                       dInEn,
  output logic [INPUT_RES_WIDTH-1:0] inXRes,
  output logic [INPUT_RES_WIDTH-1:0] inYRes,
  output logic [INPUT_RES_WIDTH-1:0] xBgn,
  output logic [INPUT_RES_WIDTH-1:0] xEnd,
  output logic [INPUT_RES_WIDTH-1:0] yBgn,
  output logic [INPUT_RES_WIDTH-1:0] yEnd,
  output logic                       resVld,
  output logic                       resChg
);

  localparam int RW = INPUT_RES_WIDTH;
  localparam logic [RW-1:0] CNT_MAX = '1;
  localparam logic [3:0]    STB_TGT = 4'(STABLE_FRAMES);

  logic h_edge, v_edge;
  logic [RW-1:0] x_cnt, y_cnt, line_len;
  logic ragged, ovf;
  logic [RW-1:0] x_inc, y_inc, y_eff, len_eff;
  logic line_close, first_line, ragged_eff, ovf_eff, frm_vld;

  res_state_t state, state_nxt;
  logic [3:0] stb_cnt, stb_nxt, stb_inc;
  logic [RW-1:0] cand_w, cand_h;
  logic cand_ld, publish, drop;
  logic match_cand, match_pub;

  logic [RW-1:0] x_res, y_res, x_end, y_end;
  logic res_vld, res_chg;

  scaler_sync_edge #(.SYNC_POL(SYNC_POL)) u_hsync_edge (
    .clka     (clka),
    .rst      (rst),
    .sync_lvl (iHsyn),
    .act_edge (h_edge)
  );

  scaler_sync_edge #(.SYNC_POL(SYNC_POL)) u_vsync_edge (
    .clka     (clka),
    .rst      (rst),
    .sync_lvl (iVsyn),
    .act_edge (v_edge)
  );

  // A line closing in the vsync cycle still belongs to the closing frame.
  assign line_close = h_edge && (x_cnt != '0);
  assign first_line = (y_cnt == '0);
  assign x_inc      = (x_cnt == CNT_MAX) ? x_cnt : x_cnt + 1'b1;
  assign y_inc      = (y_cnt == CNT_MAX) ? y_cnt : y_cnt + 1'b1;
  assign y_eff      = line_close ? y_inc : y_cnt;
  assign len_eff    = (line_close && first_line) ? x_cnt : line_len;
  assign ragged_eff = ragged || (line_close && !first_line && (x_cnt != line_len));
  assign ovf_eff    = ovf || (line_close && (y_inc == CNT_MAX));
  assign frm_vld    = (y_eff != '0) && !ragged_eff && !ovf_eff;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      line_len <= '0;
      ragged   <= 1'b0;
      ovf      <= 1'b0;
    end else if (v_edge) begin
      x_cnt    <= {{(RW-1){1'b0}}, dInEn};
      y_cnt    <= '0;
      line_len <= '0;
      ragged   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (h_edge) begin
        x_cnt <= {{(RW-1){1'b0}}, dInEn};
      end else if (dInEn) begin
        x_cnt <= x_inc;
        if (x_inc == CNT_MAX) ovf <= 1'b1;
      end
      if (line_close) begin
        y_cnt <= y_inc;
        if (y_inc == CNT_MAX) ovf <= 1'b1;
        if (first_line)             line_len <= x_cnt;
        else if (x_cnt != line_len) ragged   <= 1'b1;
      end
    end
  end

  assign match_cand = (len_eff == cand_w) && (y_eff == cand_h);
  assign match_pub  = (len_eff == x_res) && (y_eff == y_res);
  assign stb_inc    = (stb_cnt == 4'hF) ? stb_cnt : stb_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    stb_nxt   = stb_cnt;
    cand_ld   = 1'b0;
    publish   = 1'b0;
    drop      = 1'b0;
    case (state)
      SEARCH: begin
        if (v_edge) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (v_edge) begin
          if (frm_vld) begin
            if (match_cand) begin
              stb_nxt = stb_inc;
            end else begin
              stb_nxt = 4'd1;
              cand_ld = 1'b1;
            end
          end else begin
            stb_nxt = 4'd0;
          end
          if (stb_nxt >= STB_TGT) begin
            publish   = 1'b1;
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (v_edge && !(frm_vld && match_pub)) begin
          drop      = 1'b1;
          state_nxt = MEASURE;
          stb_nxt   = frm_vld ? 4'd1 : 4'd0;
          cand_ld   = frm_vld;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state   <= SEARCH;
      stb_cnt <= '0;
      cand_w  <= '0;
      cand_h  <= '0;
      x_res   <= '0;
      y_res   <= '0;
      x_end   <= '0;
      y_end   <= '0;
      res_vld <= 1'b0;
      res_chg <= 1'b0;
    end else begin
      state   <= state_nxt;
      stb_cnt <= stb_nxt;
      res_chg <= publish;
      if (cand_ld) begin
        cand_w <= len_eff;
        cand_h <= y_eff;
      end
      // Published values only move together with the resChg pulse.
      if (publish) begin
        x_res   <= len_eff;
        y_res   <= y_eff;
        x_end   <= len_eff - 1'b1;
        y_end   <= y_eff - 1'b1;
        res_vld <= 1'b1;
      end else if (drop) begin
        res_vld <= 1'b0;
      end
    end
  end

  assign inXRes = x_res;
  assign inYRes = y_res;
  assign xEnd   = x_end;
  assign yEnd   = y_end;
  assign xBgn   = '0;
  assign yBgn   = '0;
  assign resVld = res_vld;
  assign resChg = res_chg;

endmodule
